segment_swapchain_n: RTL and testbench
======================================

SEGMENT_SWAPCHAIN_N -- requirements
Module: segment_swapchain_n

Interface
REQ-001 Parameter NumSegment, default 4, number of segments (>=2).
REQ-002 Parameter IdxWidth, default 16, width of CYCLE/SYNC_IDX/IDX.
REQ-003 Parameter NumGpio, default 4, number of GPIO trigger inputs.
REQ-004 CLK  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 SYS_TIME  in  57  current system time.
REQ-007 UPDATE_SETTINGS  in  1  single-cycle request strobe.
REQ-008 REQ_SEGMENT  in  $clog2(NumSegment)  requested segment.
REQ-009 TRANSITION_MODE  in  8  codes: SYNC_IDX 8'h00, SYS_TIME 8'h01, GPIO 8'h02, EXT 8'hF0, IMMEDIATE 8'hFF.
REQ-010 TRANSITION_TIME  in  57  target time, same units as SYS_TIME.
REQ-011 GPIO_SEL  in  $clog2(NumGpio)  GPIO trigger select.
REQ-012 EXT_MASK  in  NumSegment  segments in the EXT rotation.
REQ-013 CYCLE[NumSegment], SYNC_IDX[NumSegment]  in  IdxWidth each; REP[NumSegment]  in  16 each (16'hFFFF = infinite).
REQ-014 GPIO_IN[NumGpio]  in  1 each.
REQ-015 STOP out 1; SEGMENT out $clog2(NumSegment); IDX[NumSegment] out IdxWidth; LOOP_CNT out 16; BUSY out 1 (high in WAIT_START); TRANSITION_DONE out 1 (one-cycle pulse).

Function
REQ-016 Per segment i: idx_old[i] <= SYNC_IDX[i] each cycle; wrap[i] = (idx_old[i] != SYNC_IDX[i]) && SYNC_IDX[i]==0; chg[i] = idx_old[i] != SYNC_IDX[i].
REQ-017 IDX[i] SHALL be idx_old[i] in sync-index mode, tic[i] in tick mode.
REQ-018 States: INFINITE_LOOP, WAIT_START, FINITE_LOOP; WAIT_START and FINITE_LOOP use the latched request (rep, segment, mode).
REQ-019 UPDATE_SETTINGS with REQ_SEGMENT >= NumSegment SHALL be ignored entirely.
REQ-020 UPDATE_SETTINGS, REP[REQ_SEGMENT]==FFFF: next cycle SEGMENT=REQ_SEGMENT, STOP=0, sync-index mode, ext_en=(mode==EXT), state INFINITE_LOOP, TRANSITION_DONE pulse.
REQ-021 UPDATE_SETTINGS, finite REP: latch rep/segment/mode/TRANSITION_TIME/GPIO_SEL, state WAIT_START; SEGMENT/IDX/STOP unchanged until trigger.
REQ-022 IMMEDIATE with finite REP: fire on the first WAIT_START cycle.
REQ-023 SYNC_IDX trigger: wrap[req].
REQ-024 SYS_TIME trigger: registered signed 58-bit diff = SYS_TIME - latched time; fire on first WAIT_START cycle >=2 cycles after entry with diff >= 0 (past time fires at entry+2).
REQ-025 GPIO trigger: chg[req] && GPIO_IN[latched GPIO_SEL].
REQ-026 On fire: SEGMENT=req, STOP=0, LOOP_CNT=0, TRANSITION_DONE pulse, FINITE_LOOP; SYNC_IDX/IMMEDIATE use sync-index mode; SYS_TIME/GPIO use tick mode with tic[req]=0.
REQ-027 Unknown mode code in WAIT_START: wait indefinitely until next UPDATE_SETTINGS.
REQ-028 FINITE_LOOP sync-index: on wrap[SEGMENT], if LOOP_CNT==rep set STOP=1 else LOOP_CNT+1.
REQ-029 FINITE_LOOP tick: on chg[SEGMENT], if tic==CYCLE[SEGMENT] then tic=0 and loop step as REQ-028, else tic+1 (IdxWidth wrap).
REQ-030 Once STOP=1, LOOP_CNT/tic/SEGMENT SHALL hold until next accepted UPDATE_SETTINGS.
REQ-031 INFINITE_LOOP, ext_en: on wrap[SEGMENT], advance SEGMENT to next set EXT_MASK bit after it, cyclic modulo NumSegment; if no other bit set, hold.
REQ-032 UPDATE_SETTINGS coinciding with a trigger, wrap or EXT advance SHALL win; the other event is discarded.
REQ-033 UPDATE_SETTINGS in WAIT_START SHALL replace the pending request.

Reset
REQ-034 RST SHALL, next edge, set SEGMENT=0, STOP=0, LOOP_CNT=0, all tic=0, all idx_old=0, BUSY=0, TRANSITION_DONE=0, ext_en=0, sync-index mode, INFINITE_LOOP; pending request discarded.
REQ-035 RST SHALL override UPDATE_SETTINGS in the same cycle.

Verification
REQ-036 REP[2]=FFFF, mode EXT, EXT_MASK=4'b1101, segment 2 -> on successive wraps SEGMENT 2->3->0->2.
REQ-037 REP[1]=1, SYNC_IDX mode, seg 1 -> switch at first SYNC_IDX[1] 0-transition, STOP=1 at 3rd wrap, LOOP_CNT=1.
REQ-038 SYS_TIME mode, time=SYS_TIME+10, CYCLE[3]=4, REP=0 -> switch when diff>=0, TRANSITION_DONE one cycle, tic 0..4, STOP=1 after 5th chg.
REQ-039 GPIO mode, GPIO_SEL=2, GPIO_IN[2]=0 -> BUSY held; raise GPIO_IN[2] -> switch on next chg[req].
REQ-040 RST asserted in FINITE_LOOP with LOOP_CNT=5 -> next cycle SEGMENT=0, LOOP_CNT=0, STOP=0, BUSY=0.
REQ-041 REQ_SEGMENT=5 (NumSegment=4) -> no state/output change.

Source files
------------

// File: rtl/segment_swapchain_n.sv
// -----------------------------------------------------------------------------
// segment_swapchain_n
//
// Selects which of NumSegment playback segments is active and decides when a
// newly requested segment takes over. Each segment has an externally driven
// sync index; a change of that index is a "step" and a change to zero is a
// "wrap" (end of one pass through the segment).
//
// A request with an infinite repeat count (16'hFFFF) switches immediately and
// loops forever, optionally rotating through the segments set in ext_mask_i on
// every wrap. A request with a finite repeat count is parked in WAIT_START
// until its trigger condition fires, then plays rep+1 passes and raises stop_o.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   sys_time_i            current system time (57 bit)
//   update_settings_i     one-cycle request strobe
//   req_segment_i         requested segment (out-of-range requests ignored)
//   transition_mode_i     00 sync-idx, 01 sys-time, 02 gpio, F0 ext, FF immediate
//   transition_time_i     target time for sys-time mode
//   gpio_sel_i            GPIO trigger select for gpio mode
//   ext_mask_i            segments in the EXT rotation (sampled live)
//   cycle_i[]             per-segment tick count per pass (tick mode)
//   sync_idx_i[]          per-segment external sync index
//   rep_i[]               per-segment repeat count, 16'hFFFF = infinite
//   gpio_in_i             GPIO trigger inputs
//   stop_o                finite playback finished
//   segment_o             active segment
//   idx_o[]               per-segment index (sync index or internal tick)
//   loop_cnt_o            completed passes in finite playback
//   busy_o                a finite request is waiting for its trigger
//   transition_done_o     one-cycle pulse when a new segment takes over
//   state_o               FSM state (0 infinite, 1 wait-start, 2 finite)
//
// Request handshake: update_settings_i is a single-cycle strobe with no ready
// back-pressure; an in-range request is always accepted on the cycle it is seen
// and takes priority over any trigger, wrap or rotation in that cycle.
// -----------------------------------------------------------------------------
module segment_swapchain_n #(
    parameter  int NumSegment = 4,
    parameter  int IdxWidth   = 16,
    parameter  int NumGpio    = 4,
    localparam int SegW       = $clog2(NumSegment),
    localparam int GpioW      = $clog2(NumGpio)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [56:0]         sys_time_i,
    input  logic                update_settings_i,
    input  logic [SegW-1:0]     req_segment_i,
    input  logic [7:0]          transition_mode_i,
    input  logic [56:0]         transition_time_i,
    input  logic [GpioW-1:0]    gpio_sel_i,
    input  logic [NumSegment-1:0] ext_mask_i,
    input  logic [IdxWidth-1:0] cycle_i    [NumSegment],
    input  logic [IdxWidth-1:0] sync_idx_i [NumSegment],
    input  logic [15:0]         rep_i      [NumSegment],
    input  logic [NumGpio-1:0]  gpio_in_i,
    output logic                stop_o,
    output logic [SegW-1:0]     segment_o,
    output logic [IdxWidth-1:0] idx_o      [NumSegment],
    output logic [15:0]         loop_cnt_o,
    output logic                busy_o,
    output logic                transition_done_o,
    output logic [1:0]          state_o
);

    localparam logic [7:0]  ModeSyncIdx   = 8'h00;
    localparam logic [7:0]  ModeSysTime   = 8'h01;
    localparam logic [7:0]  ModeGpio      = 8'h02;
    localparam logic [7:0]  ModeExt       = 8'hF0;
    localparam logic [7:0]  ModeImmediate = 8'hFF;
    localparam logic [15:0] RepInfinite   = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_INFINITE = 2'd0,
        ST_WAIT     = 2'd1,
        ST_FINITE   = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q;
    logic [SegW-1:0]     segment_q;
    logic                stop_q;
    logic [15:0]         loop_cnt_q;
    logic                ext_en_q;
    logic                tick_mode_q;   // 0: idx_o shows sync index, 1: internal tick
    logic                done_q;
    logic [IdxWidth-1:0] idx_old_q [NumSegment];
    logic [IdxWidth-1:0] tic_q     [NumSegment];

    // Latched pending request
    logic [15:0]         rep_l_q;
    logic [SegW-1:0]     seg_l_q;
    logic [7:0]          mode_l_q;
    logic [56:0]         time_l_q;
    logic [GpioW-1:0]    gsel_l_q;

    // Cycles spent in WAIT_START, saturating at 2. The time difference is
    // registered and still reflects the previous target on the entry cycle,
    // so the sys-time trigger is held off until the fresh value is in place.
    logic [1:0]          wait_cnt_q;
    logic signed [57:0]  diff_q;

    // ------------------------------------------------------------------
    // Per-segment step / wrap detection
    // ------------------------------------------------------------------
    logic [NumSegment-1:0] chg;
    logic [NumSegment-1:0] wrap;

    always_comb begin
        chg  = '0;
        wrap = '0;
        for (int i = 0; i < NumSegment; i++) begin
            chg[i]  = (idx_old_q[i] != sync_idx_i[i]);
            wrap[i] = chg[i] && (sync_idx_i[i] == '0);
        end
    end

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic req_ok;
    logic req_inf;

    assign req_ok  = (32'(req_segment_i) < 32'(NumSegment));
    assign req_inf = (rep_i[req_segment_i] == RepInfinite);

    // ------------------------------------------------------------------
    // Trigger for the pending request. EXT has no finite-mode trigger and,
    // like any unknown code, parks the request until it is replaced.
    // ------------------------------------------------------------------
    logic fire;

    always_comb begin
        fire = 1'b0;
        case (mode_l_q)
            ModeImmediate: fire = 1'b1;
            ModeSyncIdx:   fire = wrap[seg_l_q];
            ModeSysTime:   fire = (wait_cnt_q == 2'd2) && !diff_q[57];
            ModeGpio:      fire = chg[seg_l_q] && gpio_in_i[gsel_l_q];
            default:       fire = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // EXT rotation: next set mask bit after the current segment, cyclic.
    // With no other bit set the current segment is kept.
    // ------------------------------------------------------------------
    logic [SegW-1:0] ext_seg_d;
    logic            ext_hit;
    logic [SegW-1:0] cand;

    always_comb begin
        ext_seg_d = segment_q;
        ext_hit   = 1'b0;
        cand      = '0;
        for (int k = 1; k < NumSegment; k++) begin
            cand = SegW'((32'(segment_q) + 32'(k)) % 32'(NumSegment));
            if (!ext_hit && ext_mask_i[cand]) begin
                ext_seg_d = cand;
                ext_hit   = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Main FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_INFINITE;
            segment_q   <= '0;
            stop_q      <= 1'b0;
            loop_cnt_q  <= '0;
            ext_en_q    <= 1'b0;
            tick_mode_q <= 1'b0;
            done_q      <= 1'b0;
            rep_l_q     <= '0;
            seg_l_q     <= '0;
            mode_l_q    <= '0;
            time_l_q    <= '0;
            gsel_l_q    <= '0;
            wait_cnt_q  <= '0;
            diff_q      <= '0;
            for (int i = 0; i < NumSegment; i++) begin
                idx_old_q[i] <= '0;
                tic_q[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < NumSegment; i++) begin
                idx_old_q[i] <= sync_idx_i[i];
            end
            diff_q <= $signed({1'b0, sys_time_i}) - $signed({1'b0, time_l_q});
            done_q <= 1'b0;

            if (update_settings_i && req_ok) begin
                if (req_inf) begin
                    segment_q   <= req_segment_i;
                    stop_q      <= 1'b0;
                    tick_mode_q <= 1'b0;
                    ext_en_q    <= (transition_mode_i == ModeExt);
                    state_q     <= ST_INFINITE;
                    done_q      <= 1'b1;
                end else begin
                    // Outputs keep their current values until the trigger.
                    rep_l_q    <= rep_i[req_segment_i];
                    seg_l_q    <= req_segment_i;
                    mode_l_q   <= transition_mode_i;
                    time_l_q   <= transition_time_i;
                    gsel_l_q   <= gpio_sel_i;
                    wait_cnt_q <= '0;
                    state_q    <= ST_WAIT;
                end
            end else begin
                case (state_q)
                    ST_INFINITE: begin
                        if (ext_en_q && wrap[segment_q]) begin
                            segment_q <= ext_seg_d;
                        end
                    end

                    ST_WAIT: begin
                        if (wait_cnt_q != 2'd2) begin
                            wait_cnt_q <= wait_cnt_q + 2'd1;
                        end
                        if (fire) begin
                            segment_q      <= seg_l_q;
                            stop_q         <= 1'b0;
                            loop_cnt_q     <= '0;
                            done_q         <= 1'b1;
                            ext_en_q       <= 1'b0;
                            state_q        <= ST_FINITE;
                            tick_mode_q    <= (mode_l_q == ModeSysTime) ||
                                              (mode_l_q == ModeGpio);
                            tic_q[seg_l_q] <= '0;
                        end
                    end

                    ST_FINITE: begin
                        if (!stop_q) begin
                            if (!tick_mode_q) begin
                                if (wrap[segment_q]) begin
                                    if (loop_cnt_q == rep_l_q) stop_q <= 1'b1;
                                    else loop_cnt_q <= loop_cnt_q + 16'd1;
                                end
                            end else if (chg[segment_q]) begin
                                if (tic_q[segment_q] == cycle_i[segment_q]) begin
                                    tic_q[segment_q] <= '0;
                                    if (loop_cnt_q == rep_l_q) stop_q <= 1'b1;
                                    else loop_cnt_q <= loop_cnt_q + 16'd1;
                                end else begin
                                    tic_q[segment_q] <= tic_q[segment_q] + IdxWidth'(1);
                                end
                            end
                        end
                    end

                    default: state_q <= ST_INFINITE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NumSegment; i++) begin
            idx_o[i] = tick_mode_q ? tic_q[i] : idx_old_q[i];
        end
    end

    assign stop_o            = stop_q;
    assign segment_o         = segment_q;
    assign loop_cnt_o        = loop_cnt_q;
    assign busy_o            = (state_q == ST_WAIT);
    assign transition_done_o = done_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_segment_swapchain_n.sv
// Directed bench for segment_swapchain_n. Five segments are used so that an
// out-of-range request index (5..7) is expressible on the 3-bit request port.
module tb_segment_swapchain_n;

  localparam int NSEG = 5;

  logic        clk;
  logic        rst;
  logic [56:0] sys_time;
  logic        update;
  logic [2:0]  req_seg;
  logic [7:0]  mode;
  logic [56:0] ttime;
  logic [1:0]  gpio_sel;
  logic [4:0]  ext_mask;
  logic [15:0] cycle_v  [NSEG];
  logic [15:0] sync_idx [NSEG];
  logic [15:0] rep      [NSEG];
  logic [3:0]  gpio_in;
  logic        stop;
  logic [2:0]  segment;
  logic [15:0] idx      [NSEG];
  logic [15:0] loop_cnt;
  logic        busy;
  logic        done;
  logic [1:0]  state;

  int n_pass  = 0;
  int n_total = 0;

  segment_swapchain_n #(.NumSegment(NSEG), .IdxWidth(16), .NumGpio(4)) u_dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .sys_time_i        (sys_time),
    .update_settings_i (update),
    .req_segment_i     (req_seg),
    .transition_mode_i (mode),
    .transition_time_i (ttime),
    .gpio_sel_i        (gpio_sel),
    .ext_mask_i        (ext_mask),
    .cycle_i           (cycle_v),
    .sync_idx_i        (sync_idx),
    .rep_i             (rep),
    .gpio_in_i         (gpio_in),
    .stop_o            (stop),
    .segment_o         (segment),
    .idx_o             (idx),
    .loop_cnt_o        (loop_cnt),
    .busy_o            (busy),
    .transition_done_o (done),
    .state_o           (state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wrap_seg(input int s);
    sync_idx[s] = 16'd1;
    step();
    sync_idx[s] = 16'd0;
    step();
  endtask

  task automatic chg_seg(input int s);
    sync_idx[s] = sync_idx[s] + 16'd1;
    step();
  endtask

  task automatic request(input int s, input logic [7:0] m);
    req_seg = 3'(s);
    mode    = m;
    update  = 1'b1;
    step();
    update  = 1'b0;
  endtask

  // checking
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_core(input string tag, input int seg, input int stp,
                          input int lc, input int bsy, input int dn);
    chk({tag, ".segment"}, 32'(segment), 32'(seg));
    chk({tag, ".stop"},    32'(stop),    32'(stp));
    chk({tag, ".loop"},    32'(loop_cnt), 32'(lc));
    chk({tag, ".busy"},    32'(busy),    32'(bsy));
    chk({tag, ".done"},    32'(done),    32'(dn));
  endtask

  initial begin
    rst = 1'b1; update = 1'b0; req_seg = '0; mode = 8'hFF; ttime = '0;
    sys_time = '0; gpio_sel = '0; ext_mask = '0; gpio_in = '0;
    for (int i = 0; i < NSEG; i++) begin
      cycle_v[i] = '0; sync_idx[i] = '0; rep[i] = 16'hFFFF;
    end

    // reset wins over a simultaneous request
    req_seg = 3'd2; update = 1'b1;
    step();
    chk_core("reset", 0, 0, 0, 0, 0);
    chk("reset.state", 32'(state), 32'd0);
    chk("reset.idx2", 32'(idx[2]), 32'd0);
    rst = 1'b0; update = 1'b0;
    step();
    chk("post_reset.segment", 32'(segment), 32'd0);

    // EXT rotation 2 -> 3 -> 0 -> 2 with mask 01101
    ext_mask = 5'b01101;
    request(2, 8'hF0);
    chk_core("ext_start", 2, 0, 0, 0, 1);
    step();
    chk("ext_done_clear", 32'(done), 32'd0);
    sync_idx[2] = 16'd3;
    step();
    chk("ext_idx2", 32'(idx[2]), 32'd3);
    chk("ext_chg_no_move", 32'(segment), 32'd2);
    sync_idx[2] = 16'd0;
    step();
    chk("ext_2to3", 32'(segment), 32'd3);
    wrap_seg(1);
    chk("ext_other_wrap", 32'(segment), 32'd3);
    wrap_seg(3);
    chk("ext_3to0", 32'(segment), 32'd0);
    wrap_seg(0);
    chk("ext_0to2", 32'(segment), 32'd2);
    ext_mask = 5'b00100;
    wrap_seg(2);
    chk("ext_hold_single", 32'(segment), 32'd2);
    ext_mask = 5'b01101;

    // unknown mode code parks the request; no EXT advance while waiting
    rep[2] = 16'd0;
    request(2, 8'h55);
    chk("unk.state", 32'(state), 32'd1);
    wrap_seg(2);
    step();
    chk_core("unk_wait", 2, 0, 0, 1, 0);

    // SYNC_IDX mode, rep 1 on segment 1 (also replaces the parked request)
    rep[1] = 16'd1;
    request(1, 8'h00);
    chk_core("sync_wait", 2, 0, 0, 1, 0);
    sync_idx[1] = 16'd1;
    step();
    chk("sync_chg_no_fire", 32'(busy), 32'd1);
    sync_idx[1] = 16'd0;
    step();
    chk_core("sync_fire", 1, 0, 0, 0, 1);
    chk("sync_fire.state", 32'(state), 32'd2);
    step();
    chk("sync_done_clear", 32'(done), 32'd0);
    wrap_seg(1);
    chk_core("sync_wrap2", 1, 0, 1, 0, 0);
    wrap_seg(1);
    chk_core("sync_wrap3", 1, 1, 1, 0, 0);
    wrap_seg(1);
    chk_core("sync_hold", 1, 1, 1, 0, 0);

    // SYS_TIME mode, target 10 ahead, CYCLE[3]=4, REP=0
    sys_time = 57'd1000; ttime = 57'd1010; cycle_v[3] = 16'd4; rep[3] = 16'd0;
    sync_idx[3] = 16'd7;
    request(3, 8'h01);
    chk_core("time_wait", 1, 1, 1, 1, 0);
    step(); step(); step();
    chk_core("time_early", 1, 1, 1, 1, 0);
    sys_time = 57'd1010;
    step();
    chk("time_diff_reg", 32'(busy), 32'd1);
    step();
    chk_core("time_fire", 3, 0, 0, 0, 1);
    chk("time_tic0", 32'(idx[3]), 32'd0);
    step();
    chk("time_done_clear", 32'(done), 32'd0);
    chg_seg(3);
    chk("time_tic1", 32'(idx[3]), 32'd1);
    chg_seg(3); chg_seg(3); chg_seg(3);
    chk("time_tic4", 32'(idx[3]), 32'd4);
    chk("time_tic4.stop", 32'(stop), 32'd0);
    chg_seg(3);
    chk_core("time_stop", 3, 1, 0, 0, 0);
    chk("time_tic_wrap", 32'(idx[3]), 32'd0);
    chg_seg(3);
    chk("time_hold_tic", 32'(idx[3]), 32'd0);

    // SYS_TIME with a target in the past fires two cycles after entry
    ttime = 57'd0; rep[0] = 16'd0;
    request(0, 8'h01);
    chk("past_e0", 32'(busy), 32'd1);
    step();
    chk("past_e1", 32'(busy), 32'd1);
    step();
    chk("past_e2", 32'(busy), 32'd1);
    step();
    chk_core("past_fire", 0, 0, 0, 0, 1);

    // GPIO mode: select latched at request time
    rep[1] = 16'd0; cycle_v[1] = 16'd2; gpio_sel = 2'd2; gpio_in = 4'b0000;
    request(1, 8'h02);
    gpio_sel = 2'd0;
    chk("gpio_wait", 32'(busy), 32'd1);
    chg_seg(1); chg_seg(1);
    chk_core("gpio_held", 0, 0, 0, 1, 0);
    gpio_in = 4'b0100;
    step();
    chk("gpio_no_chg", 32'(busy), 32'd1);
    chg_seg(1);
    chk_core("gpio_fire", 1, 0, 0, 0, 1);
    chk("gpio_tic0", 32'(idx[1]), 32'd0);
    chg_seg(1); chg_seg(1);
    chk("gpio_tic2", 32'(idx[1]), 32'd2);
    chg_seg(1);
    chk("gpio_stop", 32'(stop), 32'd1);

    // out-of-range requests are ignored
    request(5, 8'hFF);
    chk_core("oor5", 1, 1, 0, 0, 0);
    chk("oor5.state", 32'(state), 32'd2);
    request(7, 8'h00);
    chk_core("oor7", 1, 1, 0, 0, 0);

    // IMMEDIATE with finite REP fires on the first WAIT_START cycle
    sync_idx[2] = 16'd9; rep[2] = 16'd3;
    request(2, 8'hFF);
    chk_core("imm_wait", 1, 1, 0, 1, 0);
    chk("imm_wait_idx2", 32'(idx[2]), 32'd0);
    step();
    chk_core("imm_fire", 2, 0, 0, 0, 1);
    chk("imm_sync_idx2", 32'(idx[2]), 32'd9);

    // a new request replaces the pending one
    rep[1] = 16'd0;
    request(1, 8'h00);
    chk("repl_wait", 32'(busy), 32'd1);
    rep[3] = 16'd0;
    request(3, 8'hFF);
    chk("repl_wait2", 32'(busy), 32'd1);
    step();
    chk_core("repl_fire", 3, 0, 0, 0, 1);

    // request coinciding with a trigger wins
    request(1, 8'h00);
    sync_idx[1] = 16'd1;
    step();
    chk("coinc_wait", 32'(busy), 32'd1);
    sync_idx[1] = 16'd0; rep[4] = 16'hFFFF;
    request(4, 8'h00);
    chk_core("coinc_win", 4, 0, 0, 0, 1);
    chk("coinc.state", 32'(state), 32'd0);
    step();
    chk("coinc_discard", 32'(segment), 32'd4);

    // reset in FINITE_LOOP with LOOP_CNT=5
    rep[4] = 16'd10;
    request(4, 8'h00);
    wrap_seg(4);
    chk_core("rst_fire", 4, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) wrap_seg(4);
    chk_core("rst_loop5", 4, 0, 5, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_core("rst_finite", 0, 0, 0, 0, 0);
    chk("rst_finite.state", 32'(state), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
